// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply loader.
package matmul_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_MAT_DIM_WIDTH = 3;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    LOAD_X = 3'd0,
    LOAD_Y = 3'd1,
    FLUSH  = 3'd2,
    START  = 3'd3,
    BUSY   = 3'd4
  } loader_state_t;

  // One bit of a one-hot bank decode: true when idx selects this bank.
  function automatic logic bank_sel(input logic [7:0] idx, input logic [7:0] bank);
    return (idx == bank);
  endfunction

endpackage

// File: rtl/matmul_loader_idx_cnt.sv
// Flat element index counter split into row/column fields, with a wrap flag
// that is high on the enabled step that rolls the index back to zero.
module mat_idx_cnt
  import matmul_pkg::*;
#(
  parameter int MAT_DIM_WIDTH = DEFAULT_MAT_DIM_WIDTH,
  parameter int ADDR_WIDTH    = 2 * MAT_DIM_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [MAT_DIM_WIDTH-1:0] r,
  output logic [MAT_DIM_WIDTH-1:0] c,
  output logic                     wrap
);

  logic [ADDR_WIDTH-1:0] cnt;

  // Advance the element index on every enabled cycle; natural overflow wraps to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {ADDR_WIDTH{1'b0}};
    end else if (en) begin
      cnt <= cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign r    = cnt[ADDR_WIDTH-1:MAT_DIM_WIDTH];
  assign c    = cnt[MAT_DIM_WIDTH-1:0];
  assign wrap = en & (cnt == {ADDR_WIDTH{1'b1}});

endmodule

// File: rtl/matmul_loader.sv
// Scatters a row-major X-then-Y element stream into the banked X/Y RAMs,
// then kicks the multiply unit and waits for it to finish.
module matmul_loader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int MAT_DIM_WIDTH = DEFAULT_MAT_DIM_WIDTH,
  parameter int MAT_DIM_SIZE  = 2 ** MAT_DIM_WIDTH,
  parameter int ADDR_WIDTH    = 2 * MAT_DIM_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic [MAT_DIM_SIZE-1:0]  x_we,
  output logic [DATA_WIDTH-1:0]    x_w_data,
  output logic [MAT_DIM_WIDTH-1:0] x_w_bank_addr,
  output logic [MAT_DIM_SIZE-1:0]  y_we,
  output logic [DATA_WIDTH-1:0]    y_w_data,
  output logic [MAT_DIM_WIDTH-1:0] y_w_bank_addr,
  output logic                     strt,
  input  logic                     mm_done,
  output logic                     busy
);

  loader_state_t             state;
  logic                      first_busy;
  logic                      accept;
  logic                      wrap;
  logic [MAT_DIM_WIDTH-1:0]  row;
  logic [MAT_DIM_WIDTH-1:0]  col;
  logic [MAT_DIM_SIZE-1:0]   col_onehot;
  logic [MAT_DIM_SIZE-1:0]   row_onehot;

  assign in_ready = ~rst & ((state == LOAD_X) | (state == LOAD_Y));
  assign accept   = in_valid & in_ready;

  mat_idx_cnt #(
    .MAT_DIM_WIDTH (MAT_DIM_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_idx_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .r    (row),
    .c    (col),
    .wrap (wrap)
  );

  // Decode row and column fields into one-hot bank selects.
  always_comb begin
    col_onehot = {MAT_DIM_SIZE{1'b0}};
    row_onehot = {MAT_DIM_SIZE{1'b0}};
    for (int b = 0; b < MAT_DIM_SIZE; b++) begin
      col_onehot[b] = bank_sel(8'(col), 8'(b));
      row_onehot[b] = bank_sel(8'(row), 8'(b));
    end
  end

  // Sequencer and registered RAM write / handshake outputs.
  // X bank c holds column c (address = row); Y bank r holds row r (address = column).
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD_X;
      first_busy    <= 1'b0;
      x_we          <= {MAT_DIM_SIZE{1'b0}};
      x_w_data      <= {DATA_WIDTH{1'b0}};
      x_w_bank_addr <= {MAT_DIM_WIDTH{1'b0}};
      y_we          <= {MAT_DIM_SIZE{1'b0}};
      y_w_data      <= {DATA_WIDTH{1'b0}};
      y_w_bank_addr <= {MAT_DIM_WIDTH{1'b0}};
      strt          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      x_we <= {MAT_DIM_SIZE{1'b0}};
      y_we <= {MAT_DIM_SIZE{1'b0}};
      strt <= 1'b0;
      case (state)
        LOAD_X: begin
          if (accept) begin
            x_we          <= col_onehot;
            x_w_data      <= in_data;
            x_w_bank_addr <= row;
            if (wrap) begin
              state <= LOAD_Y;
            end else begin
              state <= LOAD_X;
            end
          end else begin
            state <= LOAD_X;
          end
        end
        LOAD_Y: begin
          if (accept) begin
            y_we          <= row_onehot;
            y_w_data      <= in_data;
            y_w_bank_addr <= col;
            if (wrap) begin
              state <= FLUSH;
            end else begin
              state <= LOAD_Y;
            end
          end else begin
            state <= LOAD_Y;
          end
        end
        FLUSH: begin
          // Final Y write commits at the end of this cycle; start the multiplier next.
          state <= START;
          strt  <= 1'b1;
          busy  <= 1'b1;
        end
        START: begin
          state      <= BUSY;
          first_busy <= 1'b1;
        end
        BUSY: begin
          // The unit may still present done from a previous job on the first cycle.
          if (first_busy) begin
            first_busy <= 1'b0;
          end else if (mm_done) begin
            state <= LOAD_X;
            busy  <= 1'b0;
          end else begin
            state <= BUSY;
          end
        end
        default: begin
          state      <= LOAD_X;
          first_busy <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench for matmul_loader: reset, scatter addressing, pulse counts,
// start/busy timing, reset mid-load, and a modelled X*Y readback.
module tb_matmul_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [7:0]  x_we;
  logic [31:0] x_w_data;
  logic [2:0]  x_w_bank_addr;
  logic [7:0]  y_we;
  logic [31:0] y_w_data;
  logic [2:0]  y_w_bank_addr;
  logic        strt;
  logic        mm_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] xbank [8][8];
  logic [31:0] ybank [8][8];
  int          xhit  [8][8];
  int          yhit  [8][8];
  int          xpulses;
  int          ypulses;
  int          bad_oh;
  int          strt_cnt = 0;

  matmul_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .x_we          (x_we),
    .x_w_data      (x_w_data),
    .x_w_bank_addr (x_w_bank_addr),
    .y_we          (y_we),
    .y_w_data      (y_w_data),
    .y_w_bank_addr (y_w_bank_addr),
    .strt          (strt),
    .mm_done       (mm_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: commits whatever write is presented at each rising edge.
  always @(posedge clk) begin
    if (x_we != 8'h00) begin
      xpulses++;
      if ($countones(x_we) != 1) bad_oh++;
      for (int b = 0; b < 8; b++)
        if (x_we[b]) begin
          xbank[b][x_w_bank_addr] = x_w_data;
          xhit[b][x_w_bank_addr]++;
        end
    end
    if (y_we != 8'h00) begin
      ypulses++;
      if ($countones(y_we) != 1) bad_oh++;
      for (int b = 0; b < 8; b++)
        if (y_we[b]) begin
          ybank[b][y_w_bank_addr] = y_w_data;
          yhit[b][y_w_bank_addr]++;
        end
    end
    if (strt) strt_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    xpulses = 0;
    ypulses = 0;
    bad_oh  = 0;
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 8; a++) begin
        xhit[b][a] = 0;
        yhit[b][a] = 0;
      end
  endtask

  // Offer one element after 'gap' idle cycles; returns 1ns after the accepting edge.
  task automatic send(input logic [31:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
    else step();
    in_valid = 1'b0;
  endtask

  // Advance until strt is seen (bounded); leaves time inside the START cycle.
  task automatic wait_strt(input string tag);
    int n;
    n = 0;
    while (!strt && n < 20) begin
      step();
      n++;
    end
    chk(tag, {63'd0, strt}, 64'd1);
  endtask

  task automatic check_hits(input string tag);
    int bad;
    bad = 0;
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 8; a++) begin
        if (xhit[b][a] != 1) bad++;
        if (yhit[b][a] != 1) bad++;
      end
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [63:0] acc;
    int          zbad;

    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    mm_done  = 1'b0;
    clear_model();

    // Reset held three cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_x_we", 64'(x_we), 64'd0);
      chk("rst_y_we", 64'(y_we), 64'd0);
      chk("rst_strt", {63'd0, strt}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Load 1: random gaps; done held high during loading must be ignored.
    clear_model();
    mm_done = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send((i == 13) ? 32'hDEAD_BEEF : 32'(100 + i), int'($urandom_range(0, 2)));
      if (i == 13) begin
        chk("x13_we", 64'(x_we), 64'h20);
        chk("x13_addr", 64'(x_w_bank_addr), 64'd1);
        chk("x13_data", 64'(x_w_data), 64'hDEAD_BEEF);
        chk("x13_y_we", 64'(y_we), 64'd0);
      end
    end
    for (int i = 0; i < 64; i++) begin
      send((i == 13) ? 32'h5 : 32'(200 + i), int'($urandom_range(0, 2)));
      if (i == 13) begin
        chk("y13_we", 64'(y_we), 64'h02);
        chk("y13_addr", 64'(y_w_bank_addr), 64'd5);
        chk("y13_data", 64'(y_w_data), 64'd5);
        chk("y13_x_we", 64'(x_we), 64'd0);
      end
    end
    mm_done = 1'b0;
    wait_strt("l1_strt_seen");
    step();                 // first BUSY cycle
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    chk("l1_first_busy_done_ignored", {63'd0, busy}, 64'd1);
    chk("l1_ready_while_busy", {63'd0, in_ready}, 64'd0);
    step();
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    chk("l1_busy_clear", {63'd0, busy}, 64'd0);
    chk("l1_ready_back", {63'd0, in_ready}, 64'd1);
    chk("l1_x_pulses", 64'(xpulses), 64'd64);
    chk("l1_y_pulses", 64'(ypulses), 64'd64);
    chk("l1_onehot", 64'(bad_oh), 64'd0);
    check_hits("l1_hits");
    chk("l1_strt_count", 64'(strt_cnt), 64'd1);

    // Load 2: X identity, Y[r][c] = 8r+c, back to back; check start timing.
    clear_model();
    for (int i = 0; i < 64; i++)
      send(((i / 8) == (i % 8)) ? 32'd1 : 32'd0, 0);
    for (int i = 0; i < 64; i++)
      send(32'(i), 0);
    chk("flush_strt_low", {63'd0, strt}, 64'd0);
    chk("flush_last_y_we", 64'(y_we), 64'h80);
    chk("flush_last_y_addr", 64'(y_w_bank_addr), 64'd7);
    step();
    chk("start_strt_high", {63'd0, strt}, 64'd1);
    chk("start_busy_high", {63'd0, busy}, 64'd1);
    step();
    chk("busy1_strt_low", {63'd0, strt}, 64'd0);
    chk("busy1_busy_high", {63'd0, busy}, 64'd1);
    repeat (68) step();
    chk("l2_busy_before_done", {63'd0, busy}, 64'd1);
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    chk("l2_busy_clear", {63'd0, busy}, 64'd0);
    chk("l2_ready_back", {63'd0, in_ready}, 64'd1);
    chk("l2_strt_count", 64'(strt_cnt), 64'd2);
    // Readback: X[i][k] lives in bank k address i, Y[k][j] in bank k address j.
    zbad = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 64'd0;
        for (int k = 0; k < 8; k++)
          acc += 64'(xbank[k][i]) * 64'(ybank[k][j]);
        if (acc !== 64'(8 * i + j)) zbad++;
      end
    chk("l2_z_equals_y", 64'(zbad), 64'd0);

    // Load 3: abort after 40 Y elements, then a complete fresh load.
    clear_model();
    for (int i = 0; i < 64; i++) send(32'(1000 + i), 0);
    for (int i = 0; i < 40; i++) send(32'(2000 + i), 0);
    step();
    rst = 1'b1;
    repeat (2) step();
    chk("abort_x_we", 64'(x_we), 64'd0);
    chk("abort_y_we", 64'(y_we), 64'd0);
    chk("abort_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    repeat (5) step();
    chk("abort_no_strt", 64'(strt_cnt), 64'd2);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    clear_model();
    send(32'd7777, 0);
    chk("fresh_first_x_we", 64'(x_we), 64'h01);
    chk("fresh_first_x_addr", 64'(x_w_bank_addr), 64'd0);
    for (int i = 1; i < 64; i++) send(32'(3000 + i), 0);
    for (int i = 0; i < 63; i++) send(32'(4000 + i), 0);
    chk("fresh_no_early_strt", 64'(strt_cnt), 64'd2);
    send(32'd4063, 0);
    wait_strt("fresh_strt_seen");
    step();
    step();
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    chk("fresh_strt_count", 64'(strt_cnt), 64'd3);
    chk("fresh_ready_back", {63'd0, in_ready}, 64'd1);
    check_hits("fresh_hits");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_loader.md
# matmul_loader

Upstream feeder for the matrix-multiply datapath. Accepts one valid/ready stream of matrix elements (all of X row-major, then all of Y row-major) and scatters each element into the banked X/Y block RAMs with the per-bank one-hot write enables and bank addresses that the multiplier's row/column reads expect. After the last Y element is written it issues a one-cycle `strt` to the multiply unit, then holds off input until the unit reports `done`.

## Interface
Parameters:
- DATA_WIDTH, 32, element width
- MAT_DIM_WIDTH, 3, log2 of matrix dimension
- MAT_DIM_SIZE, 2**MAT_DIM_WIDTH, matrix dimension N (banks per matrix)
- ADDR_WIDTH, 2*MAT_DIM_WIDTH, flat element index width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  stream element present
- in_data  in  DATA_WIDTH  stream element
- in_ready  out  1  loader accepts element this cycle
- x_we  out  MAT_DIM_SIZE  one-hot X bank write enable
- x_w_data  out  DATA_WIDTH  X write data
- x_w_bank_addr  out  MAT_DIM_WIDTH  X write address (within bank)
- y_we  out  MAT_DIM_SIZE  one-hot Y bank write enable
- y_w_data  out  DATA_WIDTH  Y write data
- y_w_bank_addr  out  MAT_DIM_WIDTH  Y write address
- strt  out  1  one-cycle start pulse to multiply unit
- mm_done  in  1  done from multiply unit
- busy  out  1  high from START until mm_done accepted

## Operation
- States: LOAD_X, LOAD_Y, FLUSH, START, BUSY. Reset state LOAD_X.
- Accept = in_valid & in_ready. in_ready = 1 in LOAD_X/LOAD_Y, 0 otherwise and 0 while rst high.
- Element counter cnt (ADDR_WIDTH bits) increments per accept; r = cnt[ADDR_WIDTH-1:MAT_DIM_WIDTH], c = cnt[MAT_DIM_WIDTH-1:0].
- X element (r,c): x_we = 1<<c, x_w_bank_addr = r (bank c holds column c; address r gives row r).
- Y element (r,c): y_we = 1<<r, y_w_bank_addr = c (bank r holds row r; address c gives column c).
- LOAD_X: accept at cnt = N*N-1 wraps cnt to 0, go to LOAD_Y. LOAD_Y: same wrap goes to FLUSH.
- FLUSH → START unconditionally; START → BUSY unconditionally; strt = 1 only in START.
- BUSY: mm_done ignored in first BUSY cycle (stale done); from the second cycle on, mm_done = 1 → LOAD_X.
- No accept → all write enables 0 next cycle; data/address outputs hold.

## Timing
- Write outputs registered: accept at edge k → we/data/addr valid during cycle k..k+1, RAM write commits at edge k+1.
- Last Y accepted at edge E: FLUSH cycle carries final y_we; strt high in the cycle after FLUSH (2 cycles after E); busy rises with strt.
- Throughput 1 element/cycle; full load with defaults = 128 accept cycles.
- Reset (any state, including mid-load): state LOAD_X, cnt 0, x_we = y_we = 0, data/addr 0, strt 0, busy 0, in_ready 0 during reset cycles. Partial RAM contents are not cleared; the next load overwrites every location.
- mm_done high outside BUSY: ignored.

## Structure
- Package matmul_pkg: loader state enum, shared DATA_WIDTH/MAT_DIM_WIDTH defaults, helper for one-hot bank decode.
- One sub-module, mat_idx_cnt: enable-driven ADDR_WIDTH wrap counter exposing r, c and a wrap flag; FSM and output registers stay in matmul_loader.

## Test plan
- Reset held 3 cycles with in_valid=1 → in_ready=0, all we 0, strt 0; first cycle after release in_ready=1.
- 14th X element (index 13, r=1,c=5), data 0xDEAD_BEEF → next cycle x_we=8'b0010_0000, x_w_bank_addr=1, x_w_data=0xDEAD_BEEF, y_we=0.
- Y index 13 (r=1,c=5), data 0x5 → y_we=8'b0000_0010, y_w_bank_addr=5.
- Random in_valid gaps over a full 128-element load → exactly 64 x_we and 64 y_we pulses, each (bank,addr) pair hit once per matrix.
- Full load with X=identity, Y[r][c]=8r+c, mm_done modeled 70 cycles after strt → strt single pulse 2 cycles after last accept, busy until mm_done, in_ready returns 1 the cycle after; Z readback equals Y.
- rst asserted after 40 Y elements, then complete fresh 128-element load → strt fires once, only after the new load; no strt from the aborted one.
